// File: rtl/m_irq_ctrl_if.sv
// m_irq_ctrl_if: register port and trap-handler request/ack bundle for m_irq_ctrl.
// Revision: 1.0
`default_nettype none

interface m_irq_ctrl_if;
  logic        bus_we;
  logic        bus_re;
  logic [1:0]  bus_addr;
  logic [63:0] bus_wdata;
  logic [63:0] bus_rdata;
  logic        bus_rvalid;
  logic        irq_en;
  logic [3:0]  irq_code;
  logic [63:0] irq_val;
  logic        irq_ack;

  modport master (
    output bus_we, bus_re, bus_addr, bus_wdata, irq_ack,
    input  bus_rdata, bus_rvalid, irq_en, irq_code, irq_val
  );

  modport slave (
    input  bus_we, bus_re, bus_addr, bus_wdata, irq_ack,
    output bus_rdata, bus_rvalid, irq_en, irq_code, irq_val
  );
endinterface

`default_nettype wire

// File: rtl/m_irq_ctrl.sv
// m_irq_ctrl: machine timer, msip and ext_irq sync, arbitrated into a trap request.
// Revision: 1.0
`default_nettype none

module m_irq_ctrl #(
  parameter int TIMER_DIV   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ext_irq,
  input  logic [63:0]       mie,
  input  logic              mstatus_mie,
  m_irq_ctrl_if.slave       bus,
  output logic [63:0]       mip,
  output logic [63:0]       mtime_o
);

  localparam logic [15:0] PRESC_MAX = 16'(TIMER_DIV - 1);
  localparam logic [3:0]  CODE_MSI  = 4'd3;
  localparam logic [3:0]  CODE_MTI  = 4'd7;
  localparam logic [3:0]  CODE_MEI  = 4'd11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    COOL = 2'd2
  } state_t;

  logic [63:0]            mtime;
  logic [63:0]            mtimecmp;
  logic                   msip;
  logic [15:0]            presc;
  logic [SYNC_STAGES-1:0] sync;
  state_t                 state;

  logic wr_msip, wr_cmp, wr_time;
  logic cand_mei, cand_msi, cand_mti, any_cand;
  logic latched_live;

  assign wr_msip = bus.bus_we && (bus.bus_addr == 2'd0);
  assign wr_cmp  = bus.bus_we && (bus.bus_addr == 2'd1);
  assign wr_time = bus.bus_we && (bus.bus_addr == 2'd2);

  assign mtime_o     = mtime;
  assign bus.irq_val = '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtime          <= '0;
      mtimecmp       <= '1;
      msip           <= 1'b0;
      presc          <= '0;
      sync           <= '0;
      mip            <= '0;
      bus.bus_rdata  <= '0;
      bus.bus_rvalid <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], ext_irq};

      // A software write to mtime takes precedence over the tick and restarts the prescaler.
      if (wr_time) begin
        mtime <= bus.bus_wdata;
        presc <= '0;
      end else if (presc == PRESC_MAX) begin
        mtime <= mtime + 64'd1;
        presc <= '0;
      end else begin
        presc <= presc + 16'd1;
      end

      if (wr_msip) msip     <= bus.bus_wdata[0];
      if (wr_cmp)  mtimecmp <= bus.bus_wdata;

      bus.bus_rvalid <= bus.bus_re;
      if (bus.bus_re) begin
        case (bus.bus_addr)
          2'd0:    bus.bus_rdata <= {63'b0, msip};
          2'd1:    bus.bus_rdata <= mtimecmp;
          2'd2:    bus.bus_rdata <= mtime;
          default: bus.bus_rdata <= '0;
        endcase
      end

      mip <= {52'b0, sync[SYNC_STAGES-1], 3'b0, (mtime >= mtimecmp), 3'b0, msip, 3'b0};
    end
  end

  assign cand_mei = mip[11] & mie[11] & mstatus_mie;
  assign cand_msi = mip[3]  & mie[3]  & mstatus_mie;
  assign cand_mti = mip[7]  & mie[7]  & mstatus_mie;
  assign any_cand = cand_mei | cand_msi | cand_mti;

  always_comb begin
    latched_live = 1'b0;
    case (bus.irq_code)
      CODE_MEI: latched_live = cand_mei;
      CODE_MSI: latched_live = cand_msi;
      CODE_MTI: latched_live = cand_mti;
      default:  latched_live = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      bus.irq_en   <= 1'b0;
      bus.irq_code <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_cand) begin
            bus.irq_en   <= 1'b1;
            bus.irq_code <= cand_mei ? CODE_MEI : (cand_msi ? CODE_MSI : CODE_MTI);
            state        <= REQ;
          end
        end
        REQ: begin
          // Ack beats withdrawal; the latched code is never re-arbitrated while held.
          if (bus.irq_ack) begin
            bus.irq_en <= 1'b0;
            state      <= COOL;
          end else if (!latched_live) begin
            bus.irq_en <= 1'b0;
            state      <= IDLE;
          end
        end
        COOL: begin
          bus.irq_en <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          bus.irq_en <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

  logic unused_mie;
  assign unused_mie = ^{mie[63:12], mie[10:8], mie[6:4], mie[2:0]};

endmodule

`default_nettype wire
